// File: rtl/flash_mode_ctrl.sv
// Chip-select policy for a no-MISO dual-flash mux: sniffs host SPI opcodes,
// applies MAIN/SECONDARY/MIRROR/AUTO mode with fault failover, counts transactions.
module flash_mode_ctrl #(
    parameter int CNT_W       = 16,
    parameter int ARM_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             h_clk,
    input  logic             h_cs_n,
    input  logic             h_mosi,
    input  logic [1:0]       cfg_mode,
    input  logic             main_fail,
    input  logic             sec_fail,
    output logic             sel0,
    output logic             sel1,
    output logic             txn_done,
    output logic             txn_is_write,
    output logic [7:0]       last_opcode,
    output logic             armed,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    typedef enum logic [1:0] {IDLE, OPCODE, DATA} state_t;

    localparam logic [1:0] MODE_MAIN   = 2'b00;
    localparam logic [1:0] MODE_SEC    = 2'b01;
    localparam logic [1:0] MODE_MIRROR = 2'b10;
    localparam logic [1:0] MODE_AUTO   = 2'b11;

    localparam int IW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] ARM_LAST = IW'((ARM_TIMEOUT > 0) ? ARM_TIMEOUT - 1 : 0);

    function automatic logic is_write_op(input logic [7:0] op);
        case (op)
            8'h06, 8'h04, 8'h01, 8'h02, 8'h20,
            8'h52, 8'hD8, 8'h60, 8'hC7: is_write_op = 1'b1;
            default:                    is_write_op = 1'b0;
        endcase
    endfunction

    // Two-flop synchronizers plus one history flop each for edge detection
    logic [1:0] cs_sync, hclk_sync, mosi_sync;
    logic       cs_prev, hclk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= 2'b11;
            hclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_prev   <= 1'b1;
            hclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], h_cs_n};
            hclk_sync <= {hclk_sync[0], h_clk};
            mosi_sync <= {mosi_sync[0], h_mosi};
            cs_prev   <= cs_sync[1];
            hclk_prev <= hclk_sync[1];
        end
    end

    logic cs_s, mosi_s, cs_fall, cs_rise, hclk_rise;
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign hclk_rise = hclk_sync[1] & ~hclk_prev;

    // Sniffer FSM
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Once 8 bits are in, the shift register is frozen and serves as the opcode latch
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    bit_cnt_d = 4'd0;
                    shift_d   = 8'h00;
                    state_d   = OPCODE;
                end
            end
            OPCODE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (hclk_rise) begin
                    shift_d   = {shift_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7)
                        state_d = DATA;
                end
            end
            DATA: begin
                if (cs_rise) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Classification and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_done     <= 1'b0;
            txn_is_write <= 1'b0;
            last_opcode  <= 8'h00;
            wr_count     <= '0;
            rd_count     <= '0;
        end else begin
            txn_done <= done_d;
            if (done_d) begin
                last_opcode  <= shift_q;
                txn_is_write <= is_write_op(shift_q);
                if (is_write_op(shift_q)) begin
                    if (wr_count != {CNT_W{1'b1}})
                        wr_count <= wr_count + 1'b1;
                end else begin
                    if (rd_count != {CNT_W{1'b1}})
                        rd_count <= rd_count + 1'b1;
                end
            end
        end
    end

    // WREN arm with idle expiry; reacts to the registered classification
    logic [IW-1:0] idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b0;
            idle_cnt <= '0;
        end else if (cfg_mode != MODE_AUTO) begin
            armed    <= 1'b0;
            idle_cnt <= '0;
        end else if (txn_done && last_opcode == 8'h06) begin
            armed    <= 1'b1;
            idle_cnt <= '0;
        end else if (txn_done && txn_is_write) begin
            armed    <= 1'b0;
            idle_cnt <= '0;
        end else if (cs_fall) begin
            idle_cnt <= '0;
        end else if (armed && state_q == IDLE && ARM_TIMEOUT != 0) begin
            if (idle_cnt == ARM_LAST) begin
                armed    <= 1'b0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

    // Target select {sel1,sel0}, fault override last
    logic [1:0] target;

    always_comb begin
        target = 2'b01;
        case (cfg_mode)
            MODE_MAIN:   target = 2'b01;
            MODE_SEC:    target = 2'b10;
            MODE_MIRROR: target = 2'b11;
            default:     target = armed ? 2'b11 : 2'b01;
        endcase
        if (main_fail && sec_fail)
            target = 2'b00;
        else if (main_fail)
            target = 2'b10;
        else if (sec_fail)
            target = 2'b01;
    end

    // Selects only move on an idle bus so a transaction never sees a switch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel0 <= 1'b1;
            sel1 <= 1'b0;
        end else if (cs_s && state_q == IDLE) begin
            sel0 <= target[0];
            sel1 <= target[1];
        end
    end

endmodule

// File: tb/tb_flash_mode_ctrl.sv
// Directed bench for flash_mode_ctrl: transaction results go through a
// scoreboard queue checked on txn_done; sel/armed are checked inline.
module tb_flash_mode_ctrl;

    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             h_clk = 1'b0;
    logic             h_cs_n = 1'b1;
    logic             h_mosi = 1'b0;
    logic [1:0]       cfg_mode = 2'b11;
    logic             main_fail = 1'b0;
    logic             sec_fail = 1'b0;
    logic             sel0, sel1, txn_done, txn_is_write, armed;
    logic [7:0]       last_opcode;
    logic [CNT_W-1:0] wr_count, rd_count;

    flash_mode_ctrl #(.CNT_W(CNT_W), .ARM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi),
        .cfg_mode(cfg_mode), .main_fail(main_fail), .sec_fail(sec_fail),
        .sel0(sel0), .sel1(sel1), .txn_done(txn_done), .txn_is_write(txn_is_write),
        .last_opcode(last_opcode), .armed(armed),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic       wr;
        int         wr_cnt;
        int         rd_cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   exp_wr = 0;
    int   exp_rd = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp)
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    function automatic logic model_is_write(input logic [7:0] op);
        return (op == 8'h06 || op == 8'h04 || op == 8'h01 || op == 8'h02 ||
                op == 8'h20 || op == 8'h52 || op == 8'hD8 || op == 8'h60 ||
                op == 8'hC7);
    endfunction

    task automatic push_txn(input logic [7:0] op);
        exp_t e;
        if (model_is_write(op)) exp_wr = (exp_wr < SAT) ? exp_wr + 1 : SAT;
        else                    exp_rd = (exp_rd < SAT) ? exp_rd + 1 : SAT;
        e.op = op; e.wr = model_is_write(op); e.wr_cnt = exp_wr; e.rd_cnt = exp_rd;
        sb.push_back(e);
    endtask

    // Monitor: every txn_done must match the oldest expected transaction
    always @(negedge clk) begin
        if (!rst && txn_done) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_txn_done actual_op=%h expected=none", last_opcode);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("txn_opcode", int'(last_opcode), int'(e.op));
                check("txn_is_write", int'(txn_is_write), int'(e.wr));
                check("txn_wr_count", int'(wr_count), e.wr_cnt);
                check("txn_rd_count", int'(rd_count), e.rd_cnt);
            end
        end
    end

    // SPI host: each half h_clk period is 4 clk, mode 0, MSB first
    task automatic cs_low();
        h_cs_n = 1'b0;
        #40;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            h_mosi = v[i];
            #40 h_clk = 1'b1;
            #40 h_clk = 1'b0;
        end
    endtask

    task automatic cs_high();
        #40 h_cs_n = 1'b1;
    endtask

    task automatic full_txn(input logic [7:0] op, input int nbytes);
        cs_low();
        send_bits(op, 8);
        for (int b = 0; b < nbytes; b++) send_bits(8'hA5 ^ 8'(b), 8);
        push_txn(op);
        cs_high();
    endtask

    task automatic check_sel(input string name, input logic [1:0] exp);
        check(name, int'({sel1, sel0}), int'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, int'({sel1, sel0}), 1);
        check({tag, "_txn_done"}, int'(txn_done), 0);
        check({tag, "_txn_is_write"}, int'(txn_is_write), 0);
        check({tag, "_last_opcode"}, int'(last_opcode), 0);
        check({tag, "_armed"}, int'(armed), 0);
        check({tag, "_wr_count"}, int'(wr_count), 0);
        check({tag, "_rd_count"}, int'(rd_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #20;
        check_reset_outputs("reset");
        rst = 1'b0;
        #40;

        // AUTO: WREN arms and mirrors, PP disarms
        full_txn(8'h06, 0);
        #80;
        check("wren_armed", int'(armed), 1);
        check_sel("wren_sel_mirror", 2'b11);
        full_txn(8'h02, 4);
        #60;
        check("pp_armed", int'(armed), 0);
        check_sel("pp_sel_main", 2'b01);

        // AUTO: read, then a 5-bit aborted transaction
        full_txn(8'h03, 3);
        #80;
        cs_low();
        send_bits(8'h15, 5);
        cs_high();
        #100;
        check("abort_rd_count", int'(rd_count), 1);
        check("abort_wr_count", int'(wr_count), 2);
        check("abort_last_opcode", int'(last_opcode), 8'h03);
        check("abort_is_write", int'(txn_is_write), 0);

        // AUTO: arm expires after 16 idle clk
        full_txn(8'h06, 0);
        #60;
        check("to_armed_early", int'(armed), 1);
        check_sel("to_sel_early", 2'b11);
        #90;
        check("to_armed_mid", int'(armed), 1);
        #100;
        check("to_armed_late", int'(armed), 0);
        check_sel("to_sel_late", 2'b01);

        // MIRROR with faults arriving mid-transaction
        cfg_mode = 2'b10;
        #30;
        check_sel("mirror_idle", 2'b11);
        cs_low();
        send_bits(8'h9F, 8);
        main_fail = 1'b1;
        send_bits(8'h00, 8);
        #30;
        check_sel("mirror_hold", 2'b11);
        push_txn(8'h9F);
        cs_high();
        #60;
        check_sel("mirror_main_fail", 2'b10);
        sec_fail = 1'b1;
        #30;
        check_sel("mirror_both_fail", 2'b00);
        main_fail = 1'b0;
        sec_fail  = 1'b0;
        #30;
        check_sel("mirror_recover", 2'b11);

        // MAIN -> SECONDARY switch while CS is low
        cfg_mode = 2'b00;
        #30;
        check_sel("main_idle", 2'b01);
        cs_low();
        send_bits(8'h0B, 8);
        cfg_mode = 2'b01;
        send_bits(8'h00, 8);
        #30;
        check_sel("switch_hold", 2'b01);
        push_txn(8'h0B);
        cs_high();
        #20;
        check_sel("switch_hold_sync", 2'b01);
        #30;
        check_sel("switch_after_rise", 2'b10);

        // Read counter saturation
        for (int n = 0; n < 17; n++) begin
            full_txn(8'h0B, 0);
            #80;
        end
        check("sat_rd_count", int'(rd_count), SAT);

        // Reset mid-opcode, then a fresh transaction
        cs_low();
        send_bits(8'h0A, 4);
        rst = 1'b1;
        #20;
        check_reset_outputs("midrst");
        h_cs_n = 1'b1;
        #40;
        rst = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        #60;
        full_txn(8'h05, 0);
        #80;
        check("post_rst_rd_count", int'(rd_count), 1);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
